// File: rtl/qoi_pixel_decoder_if.sv
// Byte-stream input and RGBA pixel output handshakes of the QOI pixel decoder.
// The decoder takes the slave side; the source/sink environment takes the master side.
interface qoi_pixel_decoder_if;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] pix_data;
    logic        pix_valid;
    logic        pix_ready;

    modport master (
        output in_data, in_valid, pix_ready,
        input  in_ready, pix_data, pix_valid
    );

    modport slave (
        input  in_data, in_valid, pix_ready,
        output in_ready, pix_data, pix_valid
    );
endinterface

// File: rtl/qoi_pixel_decoder.sv
// Streaming QOI chunk decoder: turns the header-stripped chunk byte stream of one
// image into raster-order RGBA pixels, then consumes and checks the 8-byte end marker.
module qoi_pixel_decoder #(
    parameter int CNT_W = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [CNT_W-1:0]     frame_pixels,
    qoi_pixel_decoder_if.slave   bus,
    output logic                 busy,
    output logic                 done,
    output logic                 err
);

    typedef enum logic [2:0] {
        S_IDLE, S_OP, S_ARG, S_EMIT, S_TRAIL, S_DONE
    } state_t;

    state_t           r_state, w_next;
    logic [31:0]      r_prev, r_pix;
    logic [31:0]      r_index [0:63];
    logic [CNT_W-1:0] r_cnt, r_frame;
    logic [6:0]       r_run;
    logic [7:0]       r_op, r_arg0, r_arg1, r_arg2;
    logic [1:0]       r_argIdx;
    logic [2:0]       r_trailIdx;
    logic             r_err;

    logic             w_inXfer, w_pixXfer, w_init, w_argLast, w_complete;
    logic             w_isRgb, w_isRgba;
    logic [31:0]      w_newPix, w_diffPix, w_lumaPix, w_rgbPix, w_rgbaPix;
    logic [6:0]       w_newRun;
    logic [7:0]       w_dg, w_dr, w_db;
    logic [5:0]       w_hash;
    logic [CNT_W-1:0] w_cntInc;

    assign bus.in_ready  = (r_state == S_OP) || (r_state == S_ARG) || (r_state == S_TRAIL);
    assign bus.pix_valid = (r_state == S_EMIT);
    assign bus.pix_data  = r_pix;
    assign busy          = (r_state != S_IDLE);
    assign done          = (r_state == S_DONE);
    assign err           = r_err;

    assign w_inXfer  = bus.in_valid && bus.in_ready;
    assign w_pixXfer = bus.pix_valid && bus.pix_ready;
    assign w_init    = (r_state == S_IDLE) && start;
    assign w_cntInc  = r_cnt + CNT_W'(1);
    assign w_isRgb   = (bus.in_data == 8'hFE);
    assign w_isRgba  = (bus.in_data == 8'hFF);
    assign w_argLast = (r_op == 8'hFE) ? (r_argIdx == 2'd2) :
                       (r_op == 8'hFF) ? (r_argIdx == 2'd3) : (r_argIdx == 2'd0);

    // Candidate pixels for every op form; all channel math wraps mod 256.
    assign w_diffPix = {r_prev[31:24] + {6'b0, bus.in_data[5:4]} - 8'd2,
                        r_prev[23:16] + {6'b0, bus.in_data[3:2]} - 8'd2,
                        r_prev[15:8]  + {6'b0, bus.in_data[1:0]} - 8'd2,
                        r_prev[7:0]};
    assign w_dg      = {2'b00, r_op[5:0]} - 8'd32;
    assign w_dr      = w_dg + {4'b0, bus.in_data[7:4]} - 8'd8;
    assign w_db      = w_dg + {4'b0, bus.in_data[3:0]} - 8'd8;
    assign w_lumaPix = {r_prev[31:24] + w_dr, r_prev[23:16] + w_dg,
                        r_prev[15:8] + w_db, r_prev[7:0]};
    assign w_rgbPix  = {r_arg0, r_arg1, bus.in_data, r_prev[7:0]};
    assign w_rgbaPix = {r_arg0, r_arg1, r_arg2, bus.in_data};

    // Reducing each channel mod 64 before multiplying gives the same mod-64 hash.
    assign w_hash = 6'(w_newPix[31:24]) * 6'd3 + 6'(w_newPix[23:16]) * 6'd5 +
                    6'(w_newPix[15:8]) * 6'd7 + 6'(w_newPix[7:0]) * 6'd11;

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next     = r_state;
        w_complete = 1'b0;
        w_newPix   = r_prev;
        w_newRun   = 7'd1;
        case (r_state)
            S_IDLE: if (start) w_next = S_OP;
            S_OP: if (w_inXfer) begin
                if (w_isRgb || w_isRgba || bus.in_data[7:6] == 2'b10) begin
                    w_next = S_ARG;
                end else begin
                    w_complete = 1'b1;
                    w_next     = S_EMIT;
                    case (bus.in_data[7:6])
                        2'b00:   w_newPix = r_index[bus.in_data[5:0]];
                        2'b01:   w_newPix = w_diffPix;
                        default: w_newRun = {1'b0, bus.in_data[5:0]} + 7'd1;
                    endcase
                end
            end
            S_ARG: if (w_inXfer && w_argLast) begin
                w_complete = 1'b1;
                w_next     = S_EMIT;
                if (r_op == 8'hFE)      w_newPix = w_rgbPix;
                else if (r_op == 8'hFF) w_newPix = w_rgbaPix;
                else                    w_newPix = w_lumaPix;
            end
            S_EMIT: if (w_pixXfer) begin
                if (w_cntInc == r_frame) w_next = S_TRAIL;
                else if (r_run == 7'd1)  w_next = S_OP;
            end
            S_TRAIL: if (w_inXfer && r_trailIdx == 3'd7) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || w_init) begin
            r_prev     <= 32'h0000_00FF;
            r_pix      <= '0;
            r_cnt      <= '0;
            r_frame    <= rst ? '0 : frame_pixels;
            r_run      <= '0;
            r_op       <= '0;
            r_arg0     <= '0;
            r_arg1     <= '0;
            r_arg2     <= '0;
            r_argIdx   <= '0;
            r_trailIdx <= '0;
            r_err      <= 1'b0;
            for (int k = 0; k < 64; k++) r_index[k] <= '0;
        end else begin
            if (w_inXfer && r_state == S_OP) begin
                r_op     <= bus.in_data;
                r_argIdx <= '0;
            end
            if (w_inXfer && r_state == S_ARG) begin
                case (r_argIdx)
                    2'd0:    r_arg0 <= bus.in_data;
                    2'd1:    r_arg1 <= bus.in_data;
                    default: r_arg2 <= bus.in_data;
                endcase
                r_argIdx <= r_argIdx + 2'd1;
            end
            if (w_complete) begin
                r_pix           <= w_newPix;
                r_prev          <= w_newPix;
                r_index[w_hash] <= w_newPix;
                r_run           <= w_newRun;
            end
            // Hitting the frame size with run left over truncates the run.
            if (r_state == S_EMIT && w_pixXfer) begin
                r_cnt <= w_cntInc;
                r_run <= r_run - 7'd1;
                if (w_cntInc == r_frame && r_run != 7'd1) r_err <= 1'b1;
            end
            if (r_state == S_TRAIL && w_inXfer) begin
                if (bus.in_data != ((r_trailIdx == 3'd7) ? 8'h01 : 8'h00)) r_err <= 1'b1;
                r_trailIdx <= r_trailIdx + 3'd1;
            end
        end
    end

endmodule

// File: tb/tb_qoi_pixel_decoder.sv
// Directed bench for qoi_pixel_decoder: each task decodes a small hand-built chunk stream
// and compares the emitted pixels, done/err/busy behaviour against hand-computed values.
module tb_qoi_pixel_decoder;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] frame_pixels;
    logic        busy, done, err;

    qoi_pixel_decoder_if bus ();

    qoi_pixel_decoder #(.CNT_W(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .frame_pixels (frame_pixels),
        .bus          (bus),
        .busy         (busy),
        .done         (done),
        .err          (err)
    );

    always #5 clk = ~clk;

    int nVec = 0;
    int nMis = 0;
    int cyc  = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [7:0]  txQ [$];
    logic [31:0] rxQ [$];
    logic [31:0] expQ [$];
    int          rxCyc [$];
    bit          doneSeen, errAtDone, sendTimeout;

    task automatic pushMarker(input bit bad);
        for (int i = 0; i < 7; i++) txQ.push_back(8'h00);
        txQ.push_back(bad ? 8'h00 : 8'h01);
    endtask

    task automatic startFrame(input int n);
        @(posedge clk); #1;
        frame_pixels = n;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic sendBytes(input int gap);
        int  waitCyc;
        logic ok;
        sendTimeout = 1'b0;
        while (txQ.size() > 0) begin
            bus.in_data  = txQ.pop_front();
            bus.in_valid = 1'b1;
            waitCyc = 0;
            do begin
                @(negedge clk);
                ok = bus.in_ready;
                @(posedge clk); #1;
                waitCyc++;
            end while (!ok && waitCyc < 300);
            if (!ok) begin
                sendTimeout = 1'b1;
                txQ.delete();
            end
            bus.in_valid = 1'b0;
            for (int g = 0; g < gap; g++) begin
                @(posedge clk); #1;
            end
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic collectPixels(input int period);
        int k = 0;
        while (!doneSeen && k < 2000) begin
            @(posedge clk); #1;
            bus.pix_ready = ((k % period) == 0);
            k++;
            @(negedge clk);
            if (bus.pix_valid && bus.pix_ready) begin
                rxQ.push_back(bus.pix_data);
                rxCyc.push_back(cyc);
            end
        end
        bus.pix_ready = 1'b1;
    endtask

    task automatic waitDone();
        int n = 0;
        while (!doneSeen && n < 3000) begin
            @(negedge clk);
            if (done) begin
                doneSeen  = 1'b1;
                errAtDone = err;
            end
            n++;
        end
    endtask

    task automatic runFrame(input int n, input int gap, input int period);
        rxQ.delete();
        rxCyc.delete();
        doneSeen  = 1'b0;
        errAtDone = 1'b0;
        startFrame(n);
        fork
            sendBytes(gap);
            collectPixels(period);
            waitDone();
        join
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        nVec++; if (bus.pix_valid !== 1'b0) begin nMis++; $display("[TB] FAIL reset_pix_valid: got %b want 0", bus.pix_valid); end
        nVec++; if (bus.in_ready !== 1'b0) begin nMis++; $display("[TB] FAIL reset_in_ready: got %b want 0", bus.in_ready); end
        nVec++; if (busy !== 1'b0) begin nMis++; $display("[TB] FAIL reset_busy: got %b want 0", busy); end
        nVec++; if (done !== 1'b0) begin nMis++; $display("[TB] FAIL reset_done: got %b want 0", done); end
        nVec++; if (err !== 1'b0) begin nMis++; $display("[TB] FAIL reset_err: got %b want 0", err); end
        nVec++; if (bus.pix_data !== 32'h0) begin nMis++; $display("[TB] FAIL reset_pix_data: got %h want 0", bus.pix_data); end
        rst = 1'b0;
    endtask

    task automatic test_rgb();
        txQ = {8'hFE, 8'h10, 8'h20, 8'h30};
        pushMarker(1'b0);
        runFrame(1, 0, 1);
        nVec++; if (rxQ.size() !== 1) begin nMis++; $display("[TB] FAIL rgb_count: got %0d want 1", rxQ.size()); end
        nVec++; if (rxQ.size() < 1 || rxQ[0] !== 32'h102030FF) begin nMis++; $display("[TB] FAIL rgb_pixel: got %h want 102030ff", (rxQ.size() > 0) ? rxQ[0] : 32'hx); end
        nVec++; if (doneSeen !== 1'b1) begin nMis++; $display("[TB] FAIL rgb_done: got %b want 1", doneSeen); end
        nVec++; if (errAtDone !== 1'b0) begin nMis++; $display("[TB] FAIL rgb_err: got %b want 0", errAtDone); end
        @(negedge clk);
        nVec++; if (busy !== 1'b0) begin nMis++; $display("[TB] FAIL rgb_busy_after_done: got %b want 0", busy); end
        nVec++; if (done !== 1'b0) begin nMis++; $display("[TB] FAIL rgb_done_one_cycle: got %b want 0", done); end
    endtask

    task automatic test_rgba_diff_luma();
        logic [31:0] got;
        txQ = {8'hFF, 8'h01, 8'h02, 8'h03, 8'h04, 8'h40, 8'h80, 8'h88};
        pushMarker(1'b0);
        expQ = {32'h01020304, 32'hFF000104, 32'hDFE0E104};
        runFrame(3, 0, 1);
        nVec++; if (rxQ.size() !== 3) begin nMis++; $display("[TB] FAIL rdl_count: got %0d want 3", rxQ.size()); end
        for (int i = 0; i < expQ.size(); i++) begin
            got = (i < rxQ.size()) ? rxQ[i] : 32'hx;
            nVec++; if (got !== expQ[i]) begin nMis++; $display("[TB] FAIL rdl_pixel%0d: got %h want %h", i, got, expQ[i]); end
        end
        nVec++; if (errAtDone !== 1'b0 || doneSeen !== 1'b1) begin nMis++; $display("[TB] FAIL rdl_done_err: got done=%b err=%b want done=1 err=0", doneSeen, errAtDone); end
    endtask

    task automatic test_run();
        bit consecutive;
        logic [31:0] got;
        txQ = {8'hFE, 8'h0A, 8'h0B, 8'h0C, 8'hC3};
        pushMarker(1'b0);
        runFrame(5, 0, 1);
        nVec++; if (rxQ.size() !== 5) begin nMis++; $display("[TB] FAIL run_count: got %0d want 5", rxQ.size()); end
        for (int i = 0; i < 5; i++) begin
            got = (i < rxQ.size()) ? rxQ[i] : 32'hx;
            nVec++; if (got !== 32'h0A0B0CFF) begin nMis++; $display("[TB] FAIL run_pixel%0d: got %h want 0a0b0cff", i, got); end
        end
        consecutive = (rxCyc.size() == 5);
        for (int i = 2; i < rxCyc.size(); i++) if (rxCyc[i] - rxCyc[i-1] != 1) consecutive = 1'b0;
        nVec++; if (consecutive !== 1'b1) begin nMis++; $display("[TB] FAIL run_back_to_back: got %b want 1", consecutive); end
        nVec++; if (errAtDone !== 1'b0) begin nMis++; $display("[TB] FAIL run_err: got %b want 0", errAtDone); end
    endtask

    task automatic test_index();
        logic [31:0] got;
        txQ = {8'hFE, 8'h0A, 8'h0B, 8'h0C, 8'hFE, 8'h00, 8'h00, 8'h00, 8'h1E};
        pushMarker(1'b0);
        expQ = {32'h0A0B0CFF, 32'h000000FF, 32'h0A0B0CFF};
        runFrame(3, 0, 1);
        nVec++; if (rxQ.size() !== 3) begin nMis++; $display("[TB] FAIL index_count: got %0d want 3", rxQ.size()); end
        for (int i = 0; i < expQ.size(); i++) begin
            got = (i < rxQ.size()) ? rxQ[i] : 32'hx;
            nVec++; if (got !== expQ[i]) begin nMis++; $display("[TB] FAIL index_pixel%0d: got %h want %h", i, got, expQ[i]); end
        end
    endtask

    task automatic test_run_overflow();
        txQ = {8'hFE, 8'h01, 8'h01, 8'h01, 8'hC5};
        pushMarker(1'b0);
        runFrame(2, 0, 1);
        nVec++; if (rxQ.size() !== 2) begin nMis++; $display("[TB] FAIL ovf_count: got %0d want 2", rxQ.size()); end
        nVec++; if (rxQ.size() < 2 || rxQ[1] !== 32'h010101FF) begin nMis++; $display("[TB] FAIL ovf_pixel1: got %h want 010101ff", (rxQ.size() > 1) ? rxQ[1] : 32'hx); end
        nVec++; if (doneSeen !== 1'b1) begin nMis++; $display("[TB] FAIL ovf_done: got %b want 1", doneSeen); end
        nVec++; if (errAtDone !== 1'b1) begin nMis++; $display("[TB] FAIL ovf_err: got %b want 1", errAtDone); end
        nVec++; if (sendTimeout !== 1'b0) begin nMis++; $display("[TB] FAIL ovf_marker_accepted: got timeout=%b want 0", sendTimeout); end
    endtask

    task automatic test_bad_marker();
        txQ = {8'hC0};
        pushMarker(1'b1);
        runFrame(1, 0, 1);
        nVec++; if (rxQ.size() < 1 || rxQ[0] !== 32'h000000FF) begin nMis++; $display("[TB] FAIL badmk_prev_reinit: got %h want 000000ff", (rxQ.size() > 0) ? rxQ[0] : 32'hx); end
        nVec++; if (doneSeen !== 1'b1 || errAtDone !== 1'b1) begin nMis++; $display("[TB] FAIL badmk_err: got done=%b err=%b want done=1 err=1", doneSeen, errAtDone); end
        @(negedge clk);
        nVec++; if (err !== 1'b1) begin nMis++; $display("[TB] FAIL badmk_err_sticky: got %b want 1", err); end
    endtask

    task automatic test_backpressure();
        logic [31:0] got;
        txQ = {8'hFF, 8'h11, 8'h22, 8'h33, 8'h44, 8'hC4, 8'hA5, 8'h2B};
        pushMarker(1'b0);
        expQ = {32'h11223344, 32'h11223344, 32'h11223344, 32'h11223344,
                32'h11223344, 32'h11223344, 32'h10273B44};
        runFrame(7, 2, 3);
        nVec++; if (rxQ.size() !== 7) begin nMis++; $display("[TB] FAIL bp_count: got %0d want 7", rxQ.size()); end
        for (int i = 0; i < expQ.size(); i++) begin
            got = (i < rxQ.size()) ? rxQ[i] : 32'hx;
            nVec++; if (got !== expQ[i]) begin nMis++; $display("[TB] FAIL bp_pixel%0d: got %h want %h", i, got, expQ[i]); end
        end
        nVec++; if (errAtDone !== 1'b0 || doneSeen !== 1'b1) begin nMis++; $display("[TB] FAIL bp_done_err: got done=%b err=%b want done=1 err=0", doneSeen, errAtDone); end
    endtask

    task automatic test_reset_midrun();
        txQ = {8'hFE, 8'h0A, 8'h0B, 8'h0C, 8'hC3};
        bus.pix_ready = 1'b1;
        startFrame(5);
        sendBytes(0);
        @(posedge clk); #1;
        nVec++; if (bus.pix_valid !== 1'b1) begin nMis++; $display("[TB] FAIL mid_run_active: got %b want 1", bus.pix_valid); end
        rst = 1'b1;
        @(posedge clk); #1;
        nVec++; if (bus.pix_valid !== 1'b0) begin nMis++; $display("[TB] FAIL mid_rst_pix_valid: got %b want 0", bus.pix_valid); end
        nVec++; if (busy !== 1'b0) begin nMis++; $display("[TB] FAIL mid_rst_busy: got %b want 0", busy); end
        rst = 1'b0;
        txQ = {8'h1E};
        pushMarker(1'b0);
        runFrame(1, 0, 1);
        nVec++; if (rxQ.size() < 1 || rxQ[0] !== 32'h00000000) begin nMis++; $display("[TB] FAIL mid_rst_index_cleared: got %h want 00000000", (rxQ.size() > 0) ? rxQ[0] : 32'hx); end
        nVec++; if (doneSeen !== 1'b1 || errAtDone !== 1'b0) begin nMis++; $display("[TB] FAIL mid_rst_fresh_frame: got done=%b err=%b want done=1 err=0", doneSeen, errAtDone); end
    endtask

    initial begin
        start         = 1'b0;
        frame_pixels  = '0;
        bus.in_data   = '0;
        bus.in_valid  = 1'b0;
        bus.pix_ready = 1'b1;
        rst           = 1'b0;
        test_reset();
        test_rgb();
        test_rgba_diff_luma();
        test_run();
        test_index();
        test_run_overflow();
        test_bad_marker();
        test_backpressure();
        test_reset_midrun();
        $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
        $finish;
    end

endmodule
